dport_resp_model: RTL and testbench
===================================

DPORT_RESP_MODEL -- requirements
Module: dport_resp_model

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h80009000, byte base address of the local window.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the window (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, accept-to-ack cycles, legal range 1..4.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, accepted-but-unacked request limit, legal range 1..8.
REQ-005 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_i  input  1  synchronous reset, active-low.
REQ-007 SHALL have port mem_d_addr_i  input  32  request byte address.
REQ-008 SHALL have port mem_d_data_wr_i  input  32  write data.
REQ-009 SHALL have port mem_d_rd_i  input  1  read request.
REQ-010 SHALL have port mem_d_wr_i  input  4  byte write strobes.
REQ-011 SHALL have port mem_d_cacheable_i  input  1  ignored.
REQ-012 SHALL have port mem_d_req_tag_i  input  11  request tag.
REQ-013 SHALL have port mem_d_invalidate_i / mem_d_writeback_i / mem_d_flush_i  input  1 each  cache maintenance requests.
REQ-014 SHALL have port resp_hold_i  input  1  bench control; holds responses in the queue.
REQ-015 SHALL have port mem_d_accept_o  output  1  request accepted this cycle.
REQ-016 SHALL have port mem_d_ack_o  output  1  response valid, one cycle per request.
REQ-017 SHALL have port mem_d_error_o  output  1  response error.
REQ-018 SHALL have port mem_d_data_rd_o  output  32  read data.
REQ-019 SHALL have port mem_d_resp_tag_o  output  11  tag of the response.

Function
REQ-020 A request SHALL be present when any of rd, |wr, invalidate, writeback, flush is high; it SHALL be taken when it is present and mem_d_accept_o is high in the same cycle.
REQ-021 mem_d_accept_o SHALL be high iff (pipeline occupancy + queue occupancy) < MAX_OUTSTANDING; it SHALL be combinational on registered counts only.
REQ-022 In-window means BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS; word index = (addr-BASE_ADDR)>>2; addr[1:0] is ignored.
REQ-023 An in-window write SHALL update only strobed bytes at the accept edge; a read SHALL sample the array at the accept edge, so program order is preserved (read after write returns new data).
REQ-024 An out-of-window read/write SHALL not modify the array; its ack SHALL carry error=1 and data 0.
REQ-025 Write, invalidate, writeback and flush acks SHALL carry data 0 and error 0 (maintenance ops are no-ops).
REQ-026 Accepted requests SHALL traverse a LATENCY-stage shift pipeline {tag, data, error}, then enter a MAX_OUTSTANDING-deep FIFO.
REQ-027 With resp_hold_i low and an empty FIFO, the ack SHALL appear exactly LATENCY cycles after the accept edge.
REQ-028 The FIFO head SHALL be presented as ack when non-empty and resp_hold_i is low; pop on that cycle; responses SHALL be in strict accept order.
REQ-029 With resp_hold_i high, no ack SHALL be issued; pipeline exits still enqueue; the outstanding limit guarantees the FIFO never overflows.
REQ-030 Simultaneous accept and ack SHALL leave the outstanding count unchanged; count SHALL never exceed MAX_OUTSTANDING or underflow.
REQ-031 Outputs mem_d_error_o, data, tag SHALL be 0 whenever mem_d_ack_o is low.

Reset
REQ-032 While rst_i is low, at each rising edge: pipeline, FIFO pointers and counts cleared; mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o SHALL be 0; mem_d_accept_o SHALL be 0.
REQ-033 Reset mid-operation SHALL drop all in-flight responses with no ack; array contents SHALL be retained (not reset).
REQ-034 mem_d_accept_o SHALL assert in the first cycle after rst_i returns high.

Verification
REQ-035 Write 0xDEADBEEF strobe 4'hF to 0x80009030 tag 5, then read same tag 6 -> ack tag 5 data 0 at +2, ack tag 6 data 0xDEADBEEF at +3.
REQ-036 Write 0x11223344 then strobe 4'b0100 data 0xAA0000 to 0x80009000, read -> 0x11AA3344.
REQ-037 Read 0x80000000 (out of window) tag 7 -> ack error=1 data 0 tag 7, array unchanged.
REQ-038 resp_hold_i high, issue 6 back-to-back reads -> accept high for 4 cycles then low, no acks; release -> 4 acks on consecutive cycles in tag order, accept reasserts.
REQ-039 Issue 3 reads, assert rst_i low one cycle before first ack -> no acks ever emitted for them, accept 1 after reset release, prior array data readable.

Source files
------------

// File: rtl/dport_resp_model.sv
// Data-port responder model: a local word memory window answered through a
// fixed-latency response pipeline followed by an in-order response FIFO.
module dport_resp_model #(
   parameter logic [31:0] BASE_ADDR       = 32'h8000_9000,
   parameter int          DEPTH_WORDS     = 1024,
   parameter int          LATENCY         = 2,
   parameter int          MAX_OUTSTANDING = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] mem_d_addr_i,
   input  logic [31:0] mem_d_data_wr_i,
   input  logic        mem_d_rd_i,
   input  logic [3:0]  mem_d_wr_i,
   input  logic        mem_d_cacheable_i,
   input  logic [10:0] mem_d_req_tag_i,
   input  logic        mem_d_invalidate_i,
   input  logic        mem_d_writeback_i,
   input  logic        mem_d_flush_i,
   input  logic        resp_hold_i,
   output logic        mem_d_accept_o,
   output logic        mem_d_ack_o,
   output logic        mem_d_error_o,
   output logic [31:0] mem_d_data_rd_o,
   output logic [10:0] mem_d_resp_tag_o
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam int          PW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int          CW        = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [32:0] WIN_BYTES = 33'(4 * DEPTH_WORDS);

   typedef struct packed {
      logic [10:0] tag;
      logic [31:0] data;
      logic        error;
   } resp_t;

   logic [31:0]          mem [DEPTH_WORDS];
   resp_t                pipe_q [LATENCY];
   logic [LATENCY-1:0]   pipe_vld_q;
   resp_t                fifo_q [MAX_OUTSTANDING];
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        fifo_cnt_q, out_cnt_q;

   logic [31:0]          offset;
   logic [AW-1:0]        word_idx;
   logic                 in_window, is_access, is_read, req_present, take;
   logic                 push, pop;
   resp_t                new_resp, head;
   logic                 unused_ok;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // Wrapping subtraction folds the lower-bound check into a single compare.
   assign offset      = mem_d_addr_i - BASE_ADDR;
   assign in_window   = {1'b0, offset} < WIN_BYTES;
   assign word_idx    = offset[AW+1:2];
   assign is_access   = mem_d_rd_i | (|mem_d_wr_i);
   assign is_read     = mem_d_rd_i & ~(|mem_d_wr_i);
   assign req_present = is_access | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
   assign take        = req_present & mem_d_accept_o;
   assign unused_ok   = ^{mem_d_cacheable_i, offset[1:0], offset[31:AW+2]};

   always_comb begin
      // NOTE: every field gets a default first so no path through the block can infer a latch.
      new_resp     = '0;
      new_resp.tag = mem_d_req_tag_i;
      if (is_access && !in_window) begin
         new_resp.error = 1'b1;
      end else if (is_read) begin
         new_resp.data = mem[word_idx];
      end
   end

   // NOTE: the storage array and the payload registers carry no reset; only the
   // valid bits, pointers and counts do, so reset never disturbs memory contents.
   always_ff @(posedge clk_i) begin
      if (take && in_window) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_d_wr_i[b]) begin
               mem[word_idx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
            end
         end
      end
      pipe_q[0] <= new_resp;
      for (int i = 1; i < LATENCY; i++) begin
         pipe_q[i] <= pipe_q[i-1];
      end
      if (push) begin
         fifo_q[wr_ptr_q] <= pipe_q[LATENCY-1];
      end
   end

   assign push = pipe_vld_q[LATENCY-1];
   assign pop  = rst_i & ~resp_hold_i & (fifo_cnt_q != '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pipe_vld_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         out_cnt_q  <= '0;
      end else begin
         pipe_vld_q[0] <= take;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
         end
         if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
         out_cnt_q  <= out_cnt_q + CW'(take) - CW'(pop);
      end
   end

   // The outstanding limit bounds pipeline plus FIFO, so the FIFO cannot overflow.
   assign mem_d_accept_o   = rst_i & (out_cnt_q < CW'(MAX_OUTSTANDING));
   assign head             = fifo_q[rd_ptr_q];
   assign mem_d_ack_o      = pop;
   assign mem_d_error_o    = pop & head.error;
   assign mem_d_data_rd_o  = pop ? head.data : '0;
   assign mem_d_resp_tag_o = pop ? head.tag : '0;

endmodule

// File: tb/tb_dport_resp_model.sv
// Randomized and directed bench for dport_resp_model, checked against a
// queue-based transaction model of the responder.
module tb_dport_resp_model;

   localparam logic [31:0] BASE  = 32'h8000_9000;
   localparam int          DEPTH = 1024;
   localparam int          LAT   = 2;
   localparam int          MAXO  = 4;
   localparam int K_IDLE = 0, K_RD = 1, K_WR = 2, K_INV = 3, K_WB = 4, K_FL = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic        rd = 1'b0, cacheable = 1'b0, inval = 1'b0, wb = 1'b0, flush = 1'b0, hold = 1'b0;
   logic [3:0]  wr = '0;
   logic [10:0] tag = '0;
   logic        accept, ack, error;
   logic [31:0] rdata;
   logic [10:0] rtag;

   dport_resp_model #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_i(rst), .mem_d_addr_i(addr), .mem_d_data_wr_i(wdata),
      .mem_d_rd_i(rd), .mem_d_wr_i(wr), .mem_d_cacheable_i(cacheable), .mem_d_req_tag_i(tag),
      .mem_d_invalidate_i(inval), .mem_d_writeback_i(wb), .mem_d_flush_i(flush),
      .resp_hold_i(hold), .mem_d_accept_o(accept), .mem_d_ack_o(ack), .mem_d_error_o(error),
      .mem_d_data_rd_o(rdata), .mem_d_resp_tag_o(rtag));

   always #5 clk = ~clk;

   typedef struct { int unsigned ready; logic [10:0] tag; logic [31:0] data; logic err; } exp_t;
   typedef struct { int unsigned cyc; logic [10:0] tag; logic [31:0] data; logic err; } ack_t;

   exp_t        q[$];
   ack_t        ack_log[$];
   logic [31:0] mem_m [int];
   int unsigned cyc = 0;
   int          n_checks = 0, n_pass = 0;
   logic        last_accept = 1'b0;
   logic [31:0] pool [11] = '{32'h8000_9000, 32'h8000_9004, 32'h8000_9008, 32'h8000_9030,
                              32'h8000_9100, 32'h8000_97FC, 32'h8000_9FF8, 32'h8000_9FFC,
                              32'h8000_0000, 32'h8000_8FFC, 32'h8000_A000};

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, obs, exp, cyc);
   endtask

   function automatic logic in_win(input logic [31:0] a);
      longint unsigned la = a;
      return la >= longint'(BASE) && la < longint'(BASE) + 4 * DEPTH;
   endfunction

   function automatic ack_t get_ack(input int i);
      ack_t none = '{32'hFFFF_FFFF, 11'h7FF, 32'hFFFF_FFFF, 1'b1};
      return (i < ack_log.size()) ? ack_log[i] : none;
   endfunction

   task automatic model_take();
      exp_t        e;
      int          idx;
      logic [31:0] w;
      e = '{cyc + LAT, tag, 32'h0, 1'b0};
      if (rd || wr != 4'h0) begin
         if (!in_win(addr)) e.err = 1'b1;
         else begin
            idx = int'((addr - BASE) >> 2);
            if (wr != 4'h0) begin
               w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
               for (int b = 0; b < 4; b++) if (wr[b]) w[8*b +: 8] = wdata[8*b +: 8];
               mem_m[idx] = w;
            end else begin
               e.data = mem_m[idx];
            end
         end
      end
      q.push_back(e);
   endtask

   // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
   task automatic tick();
      logic exp_acc, exp_ack, present;
      exp_t h;
      @(negedge clk);
      exp_acc = rst && (q.size() < MAXO);
      exp_ack = rst && !hold && q.size() != 0 && q[0].ready <= cyc;
      h = '{0, 11'h0, 32'h0, 1'b0};
      if (exp_ack) h = q[0];
      check("accept", 32'(accept), 32'(exp_acc));
      check("ack",    32'(ack),    32'(exp_ack));
      check("error",  32'(error),  32'(h.err));
      check("data",   rdata,       h.data);
      check("tag",    32'(rtag),   32'(h.tag));
      last_accept = accept;
      if (ack) ack_log.push_back('{cyc, rtag, rdata, error});
      present = rd || wr != 4'h0 || inval || wb || flush;
      @(posedge clk);
      cyc++;
      if (!rst) q.delete();
      else begin
         if (exp_ack) void'(q.pop_front());
         if (exp_acc && present) model_take();
      end
      #1;
   endtask

   task automatic drive(input int kind, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [10:0] t);
      addr  = a;  wdata = d;  tag = t;
      rd    = (kind == K_RD);
      wr    = (kind == K_WR) ? s : 4'h0;
      inval = (kind == K_INV);
      wb    = (kind == K_WB);
      flush = (kind == K_FL);
   endtask

   task automatic op(input int kind, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [10:0] t);
      drive(kind, a, d, s, t);
      tick();
      drive(K_IDLE, 32'h0, 32'h0, 4'h0, 11'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int          n_acc;
   int unsigned t0;
   ack_t        a0;

   initial begin
      // Reset: outputs quiet and accept low while rst is held.
      idle(3);
      check("rst_accept", 32'(last_accept), 32'h0);
      rst = 1'b1;
      tick();
      check("rst_release_accept", 32'(last_accept), 32'h1);

      for (int i = 0; i < 8; i++) op(K_WR, pool[i], $urandom, 4'hF, 11'(i));
      idle(6);

      // Write then read back with fixed latency.
      ack_log.delete();
      op(K_WR, 32'h8000_9030, 32'hDEAD_BEEF, 4'hF, 11'd5);
      t0 = cyc;
      op(K_RD, 32'h8000_9030, 32'h0, 4'h0, 11'd6);
      idle(5);
      check("r035_count", 32'(ack_log.size()), 32'd2);
      a0 = get_ack(0);
      check("r035_wr_tag", 32'(a0.tag), 32'd5);
      check("r035_wr_cyc", a0.cyc, t0 + 2);
      check("r035_wr_data", a0.data, 32'h0);
      a0 = get_ack(1);
      check("r035_rd_tag", 32'(a0.tag), 32'd6);
      check("r035_rd_cyc", a0.cyc, t0 + 3);
      check("r035_rd_data", a0.data, 32'hDEAD_BEEF);

      // Byte-strobed merge.
      ack_log.delete();
      op(K_WR, 32'h8000_9000, 32'h1122_3344, 4'hF, 11'd8);
      op(K_WR, 32'h8000_9000, 32'h00AA_0000, 4'b0100, 11'd9);
      op(K_RD, 32'h8000_9000, 32'h0, 4'h0, 11'd10);
      idle(5);
      a0 = get_ack(2);
      check("r036_tag", 32'(a0.tag), 32'd10);
      check("r036_data", a0.data, 32'h11AA_3344);

      // Out-of-window accesses error and leave the array alone; maintenance is a no-op.
      ack_log.delete();
      op(K_RD, 32'h8000_0000, 32'h0, 4'h0, 11'd7);
      op(K_WR, 32'h8000_A000, 32'hBAD0_BAD0, 4'hF, 11'd12);
      op(K_INV, 32'h8000_0000, 32'h0, 4'h0, 11'd15);
      op(K_RD, 32'h8000_9000, 32'h0, 4'h0, 11'd13);
      op(K_RD, 32'h8000_9FFC, 32'h0, 4'h0, 11'd14);
      idle(5);
      a0 = get_ack(0);
      check("r037_tag", 32'(a0.tag), 32'd7);
      check("r037_err", 32'(a0.err), 32'h1);
      check("r037_data", a0.data, 32'h0);
      a0 = get_ack(1);
      check("r037_wr_err", 32'(a0.err), 32'h1);
      a0 = get_ack(2);
      check("r037_maint_err", 32'(a0.err), 32'h0);
      a0 = get_ack(3);
      check("r037_unchanged", a0.data, 32'h11AA_3344);

      // Hold: accept saturates at the outstanding limit, then drains in order.
      ack_log.delete();
      hold  = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         op(K_RD, pool[i], 32'h0, 4'h0, 11'(20 + i));
         n_acc += int'(last_accept);
      end
      idle(3);
      check("r038_accepts", 32'(n_acc), 32'd4);
      check("r038_held", 32'(ack_log.size()), 32'd0);
      hold = 1'b0;
      idle(6);
      check("r038_count", 32'(ack_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         a0 = get_ack(i);
         check("r038_order", 32'(a0.tag), 32'(20 + i));
         check("r038_consec", a0.cyc, get_ack(0).cyc + 32'(i));
      end
      check("r038_reaccept", 32'(last_accept), 32'h1);

      // Reset one cycle before the first ack drops everything in flight.
      ack_log.delete();
      op(K_RD, 32'h8000_9030, 32'h0, 4'h0, 11'd1);
      drive(K_RD, 32'h8000_9000, 32'h0, 4'h0, 11'd2);
      tick();
      drive(K_RD, 32'h8000_9004, 32'h0, 4'h0, 11'd3);
      rst = 1'b0;
      tick();
      drive(K_IDLE, 32'h0, 32'h0, 4'h0, 11'h0);
      tick();
      rst = 1'b1;
      tick();
      check("r039_accept", 32'(last_accept), 32'h1);
      idle(6);
      check("r039_no_acks", 32'(ack_log.size()), 32'd0);
      op(K_RD, 32'h8000_9030, 32'h0, 4'h0, 11'd11);
      idle(4);
      a0 = get_ack(0);
      check("r039_retained", a0.data, 32'hDEAD_BEEF);

      // Randomized traffic with occasional hold bursts.
      for (int i = 0; i < 400; i++) begin
         int r;
         if ($urandom_range(0, 9) == 0) hold = ~hold;
         r = int'($urandom_range(0, 99));
         drive(r < 40 ? K_RD : r < 70 ? K_WR : r < 80 ? int'($urandom_range(K_INV, K_FL)) : K_IDLE,
               pool[$urandom_range(0, 10)], $urandom, 4'($urandom_range(1, 15)), 11'($urandom));
         tick();
      end
      drive(K_IDLE, 32'h0, 32'h0, 4'h0, 11'h0);
      hold = 1'b0;
      idle(12);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
